// File: rtl/sad_search_ctrl.sv
// Full-search motion-estimation scheduler: issues every candidate MV in a +/-SR window
// in raster order to a pipelined SAD datapath and tracks the minimum-SAD result.
module sad_search_ctrl #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned SR         = 4,
    parameter int unsigned MVW        = 4,
    parameter int unsigned PIPE_STATE = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               ref_rdy_i,
    input  logic [WIDTH+7:0]   sad_i,
    input  logic               sad_vld_i,
    output logic               cal_en_o,
    output logic [MVW-1:0]     cand_x_o,
    output logic [MVW-1:0]     cand_y_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH+7:0]   best_sad_o,
    output logic [MVW-1:0]     best_mvx_o,
    output logic [MVW-1:0]     best_mvy_o
);

    localparam int unsigned SADW  = WIDTH + 8;
    localparam int unsigned NCAND = (2 * SR + 1) * (2 * SR + 1);
    localparam int unsigned CNTW  = $clog2(NCAND + 1);
    localparam int unsigned FLW   = $clog2(PIPE_STATE + 2);
    localparam logic [MVW-1:0] MV_MAX = MVW'(SR);
    localparam logic [MVW-1:0] MV_MIN = MVW'(0) - MV_MAX;

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, DONE, FLUSH} state_e;

    state_e            state_q, state_d;
    logic [MVW-1:0]    cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    logic [MVW-1:0]    rx_q, rx_d, ry_q, ry_d;
    logic [CNTW-1:0]   issue_cnt_q, issue_cnt_d, ret_cnt_q, ret_cnt_d;
    logic [FLW-1:0]    flush_cnt_q, flush_cnt_d;
    logic [SADW-1:0]   best_sad_q, best_sad_d;
    logic [MVW-1:0]    best_mvx_q, best_mvx_d, best_mvy_q, best_mvy_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              track;

    always_comb begin
        state_d     = state_q;
        cand_x_d    = cand_x_q;
        cand_y_d    = cand_y_q;
        rx_d        = rx_q;
        ry_d        = ry_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        flush_cnt_d = flush_cnt_q;
        best_sad_d  = best_sad_q;
        best_mvx_d  = best_mvx_q;
        best_mvy_d  = best_mvy_q;
        cal_en_o    = (state_q == ISSUE) && ref_rdy_i;
        track       = sad_vld_i && !abort_i && ((state_q == ISSUE) || (state_q == DRAIN));

        // Results return in issue order, so a second raster walker names each one.
        if (track) begin
            ret_cnt_d = ret_cnt_q + CNTW'(1);
            if (sad_i < best_sad_q) begin
                best_sad_d = sad_i;
                best_mvx_d = rx_q;
                best_mvy_d = ry_q;
            end
            if (rx_q == MV_MAX) begin
                rx_d = MV_MIN;
                ry_d = ry_q + MVW'(1);
            end else begin
                rx_d = rx_q + MVW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d     = ISSUE;
                    cand_x_d    = MV_MIN;
                    cand_y_d    = MV_MIN;
                    rx_d        = MV_MIN;
                    ry_d        = MV_MIN;
                    best_sad_d  = '1;
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                end
            end
            ISSUE: begin
                if (abort_i) begin
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                end else if (cal_en_o) begin
                    if (issue_cnt_q == CNTW'(NCAND - 1)) begin
                        state_d = DRAIN;
                    end else begin
                        issue_cnt_d = issue_cnt_q + CNTW'(1);
                        if (cand_x_q == MV_MAX) begin
                            cand_x_d = MV_MIN;
                            cand_y_d = cand_y_q + MVW'(1);
                        end else begin
                            cand_x_d = cand_x_q + MVW'(1);
                        end
                    end
                end
            end
            DRAIN: begin
                if (abort_i) begin
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                end else if (ret_cnt_d == CNTW'(NCAND)) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            FLUSH: begin
                if (flush_cnt_q == FLW'(PIPE_STATE)) begin
                    state_d = IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + FLW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cand_x_q    <= '0;
            cand_y_q    <= '0;
            rx_q        <= '0;
            ry_q        <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            flush_cnt_q <= '0;
            best_sad_q  <= '0;
            best_mvx_q  <= '0;
            best_mvy_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_x_q    <= cand_x_d;
            cand_y_q    <= cand_y_d;
            rx_q        <= rx_d;
            ry_q        <= ry_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            best_sad_q  <= best_sad_d;
            best_mvx_q  <= best_mvx_d;
            best_mvy_q  <= best_mvy_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cand_x_o   = cand_x_q;
    assign cand_y_o   = cand_y_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign best_sad_o = best_sad_q;
    assign best_mvx_o = best_mvx_q;
    assign best_mvy_o = best_mvy_q;

endmodule
